// File: rtl/conv33_window_gen.sv
// 3x3 sliding-window generator: raster pixel stream in, registered 3x3 taps plus a
// one-cycle conv33_en strobe out for every unpadded window of an IMG_H x IMG_W frame.
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int CNT_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic signed [DATA_WIDTH-1:0] pix_in,
  input  logic                         pix_valid,
  output logic                         busy,
  output logic signed [DATA_WIDTH-1:0] data_0_0,
  output logic signed [DATA_WIDTH-1:0] data_0_1,
  output logic signed [DATA_WIDTH-1:0] data_0_2,
  output logic signed [DATA_WIDTH-1:0] data_1_0,
  output logic signed [DATA_WIDTH-1:0] data_1_1,
  output logic signed [DATA_WIDTH-1:0] data_1_2,
  output logic signed [DATA_WIDTH-1:0] data_2_0,
  output logic signed [DATA_WIDTH-1:0] data_2_1,
  output logic signed [DATA_WIDTH-1:0] data_2_2,
  output logic                         conv33_en,
  output logic [CNT_W-1:0]             win_row,
  output logic [CNT_W-1:0]             win_col,
  output logic                         frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                               state_q, state_d;
  logic                                 accept;
  logic [CNT_W-1:0]                     row_q, row_d, col_q, col_d;
  logic                                 last_col, last_row, emit;
  logic [AW-1:0]                        lb_idx;
  logic [DATA_WIDTH-1:0]                lb0_mem [IMG_W];
  logic [DATA_WIDTH-1:0]                lb1_mem [IMG_W];
  logic [2:0][2:0][DATA_WIDTH-1:0]      sr_q, sr_d;
  logic [2:0][2:0][DATA_WIDTH-1:0]      tap_q, tap_d;
  logic                                 en_q, en_d, done_q, done_d;
  logic [CNT_W-1:0]                     win_row_q, win_row_d, win_col_q, win_col_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = RUN;
      RUN:     if (accept && last_row && last_col) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == RUN);
    accept = busy && pix_valid;
  end

  assign last_col = (col_q == CNT_W'(IMG_W - 1));
  assign last_row = (row_q == CNT_W'(IMG_H - 1));
  assign lb_idx   = col_q[AW-1:0];
  // Columns 0-1 only prime the shift register, so a window never straddles a row edge.
  assign emit     = accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q != RUN) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[r][0] = sr_q[r][1];
        sr_d[r][1] = sr_q[r][2];
      end
      sr_d[0][2] = lb0_mem[lb_idx];
      sr_d[1][2] = lb1_mem[lb_idx];
      sr_d[2][2] = pix_in;
    end
  end

  // Output taps are a separate bank so they hold while the shift register keeps priming.
  always_comb begin
    tap_d     = emit ? sr_d : tap_q;
    win_row_d = emit ? row_q - CNT_W'(2) : win_row_q;
    win_col_d = emit ? col_q - CNT_W'(2) : win_col_q;
    en_d      = emit;
    done_d    = accept && last_row && last_col;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q     <= '0;
      col_q     <= '0;
      sr_q      <= '0;
      tap_q     <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      sr_q      <= sr_d;
      tap_q     <= tap_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      en_q      <= en_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[lb_idx] <= lb1_mem[lb_idx];
      lb1_mem[lb_idx] <= pix_in;
    end
  end

  assign data_0_0   = tap_q[0][0];
  assign data_0_1   = tap_q[0][1];
  assign data_0_2   = tap_q[0][2];
  assign data_1_0   = tap_q[1][0];
  assign data_1_1   = tap_q[1][1];
  assign data_1_2   = tap_q[1][2];
  assign data_2_0   = tap_q[2][0];
  assign data_2_1   = tap_q[2][1];
  assign data_2_2   = tap_q[2][2];
  assign conv33_en  = en_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv33_window_gen.sv
// Directed bench: a 4x4 instance against a hand-computed window table, plus a
// default 28x28 instance against a pixel-value reference.
module tb_conv33_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic              fs_s, pv_s, busy_s, en_s, done_s;
  logic signed [7:0] pix_s;
  logic [4:0]        wr_s, wc_s;
  logic signed [7:0] s00, s01, s02, s10, s11, s12, s20, s21, s22;
  logic [71:0]       taps_s;
  assign taps_s = {s00, s01, s02, s10, s11, s12, s20, s21, s22};

  logic              fs_d, pv_d, busy_d, en_d, done_d;
  logic signed [7:0] pix_d;
  logic [4:0]        wr_d, wc_d;
  logic signed [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic [71:0]       taps_d;
  assign taps_d = {d00, d01, d02, d10, d11, d12, d20, d21, d22};

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .CNT_W(5)) dut_s (
    .clk(clk), .rst(rst), .frame_start(fs_s), .pix_in(pix_s), .pix_valid(pv_s),
    .busy(busy_s),
    .data_0_0(s00), .data_0_1(s01), .data_0_2(s02),
    .data_1_0(s10), .data_1_1(s11), .data_1_2(s12),
    .data_2_0(s20), .data_2_1(s21), .data_2_2(s22),
    .conv33_en(en_s), .win_row(wr_s), .win_col(wc_s), .frame_done(done_s)
  );

  conv33_window_gen dut_d (
    .clk(clk), .rst(rst), .frame_start(fs_d), .pix_in(pix_d), .pix_valid(pv_d),
    .busy(busy_d),
    .data_0_0(d00), .data_0_1(d01), .data_0_2(d02),
    .data_1_0(d10), .data_1_1(d11), .data_1_2(d12),
    .data_2_0(d20), .data_2_1(d21), .data_2_2(d22),
    .conv33_en(en_d), .win_row(wr_d), .win_col(wc_d), .frame_done(done_d)
  );

  typedef struct {
    int         trig;   // 1-based pixel number whose accept produces the window
    logic [4:0] row;
    logic [4:0] col;
    logic [71:0] taps;
  } win_t;

  win_t tbl [4];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Pulses frame_start with a junk pixel presented in IDLE, which must be ignored.
  task automatic start_small();
    fs_s = 1'b1; pv_s = 1'b1; pix_s = 8'sd77;
    @(posedge clk); #1;
    fs_s = 1'b0; pv_s = 1'b0;
    chk("start_busy", busy_s, 1);
    chk("start_en", en_s, 0);
  endtask

  task automatic feed_small(input int gap_pct, input int fs_mid, input int abort_n);
    int n; int w; int cyc; logic [71:0] hold;
    n = 0; w = 0; cyc = 0; hold = '0;
    while (n < 16) begin
      pv_s  = ($urandom_range(0, 99) >= gap_pct);
      pix_s = 8'(n + 1);
      fs_s  = (n == fs_mid);
      @(posedge clk); #1;
      fs_s = 1'b0;
      cyc++;
      if (cyc > 1000) begin
        chk("feed_timeout", 1, 0);
        break;
      end
      if (pv_s) begin
        n++;
        if (w < 4 && tbl[w].trig == n) begin
          chk("win_en", en_s, 1);
          chk("win_taps", taps_s, tbl[w].taps);
          chk("win_pos", {wr_s, wc_s}, {tbl[w].row, tbl[w].col});
          chk("win_done", done_s, (w == 3));
          hold = tbl[w].taps;
          w++;
        end else begin
          chk("noemit_en", en_s, 0);
          chk("noemit_done", done_s, 0);
          if (w > 0) chk("noemit_hold", taps_s, hold);
        end
        chk("busy", busy_s, (n < 16));
        if (n == abort_n) break;
      end else begin
        chk("gap_en", en_s, 0);
        if (w > 0) chk("gap_hold", taps_s, hold);
      end
    end
    pv_s = 1'b0;
  endtask

  // Called in the DONE cycle: a pixel offered here must be ignored.
  task automatic post_done();
    pv_s = 1'b1; pix_s = 8'sd99;
    @(posedge clk); #1;
    pv_s = 1'b0;
    chk("post_busy", busy_s, 0);
    chk("post_en", en_s, 0);
    chk("post_done", done_s, 0);
  endtask

  function automatic logic [7:0] pval(input int r, input int c);
    return 8'((r * 28 + c) % 128);
  endfunction

  initial begin
    int strobes; int maxcol; logic [71:0] exp_t; int r; int c;

    tbl[0] = '{11, 5'd0, 5'd0, {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};
    tbl[1] = '{12, 5'd0, 5'd1, {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12}};
    tbl[2] = '{15, 5'd1, 5'd0, {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}};
    tbl[3] = '{16, 5'd1, 5'd1, {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16}};

    rst = 1'b0;
    fs_s = 1'b0; pv_s = 1'b0; pix_s = '0;
    fs_d = 1'b0; pv_d = 1'b0; pix_d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_s", busy_s, 0);
    chk("rst_en_s", en_s, 0);
    chk("rst_taps_s", taps_s, 0);
    chk("rst_win_s", {wr_s, wc_s, done_s}, 0);
    chk("rst_all_d", {busy_d, en_d, done_d, wr_d, wc_d, taps_d}, 0);
    rst = 1'b1;

    // Frame with no gaps, then the same frame with 50% valid duty.
    start_small(); feed_small(0, -1, -1);  post_done();
    start_small(); feed_small(50, -1, -1); post_done();

    // frame_start mid-RUN ignored; next frame started in the cycle right after DONE.
    start_small(); feed_small(30, 5, -1);  post_done();
    start_small(); feed_small(0, -1, -1);  post_done();

    // Abort after pixel 10 with a one-cycle reset.
    start_small(); feed_small(0, -1, 10);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_outs", {busy_s, en_s, done_s, wr_s, wc_s}, 0);
    chk("abort_taps", taps_s, 0);
    pv_s = 1'b1; pix_s = 8'sd55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_ignore", {busy_s, en_s, done_s}, 0);
    end
    pv_s = 1'b0;
    start_small(); feed_small(0, -1, -1); post_done();

    // Default 28x28 frame against the pixel-value reference.
    fs_d = 1'b1;
    @(posedge clk); #1;
    fs_d = 1'b0;
    strobes = 0; maxcol = 0;
    for (int n = 0; n < 784; n++) begin
      r = n / 28; c = n % 28;
      pv_d = 1'b1; pix_d = 8'(pval(r, c));
      @(posedge clk); #1;
      chk("big_en", en_d, (r >= 2 && c >= 2));
      if (r >= 2 && c >= 2) begin
        strobes++;
        exp_t = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_t = {exp_t[63:0], pval(r - 2 + i, c - 2 + j)};
        chk("big_taps", taps_d, exp_t);
        chk("big_pos", {wr_d, wc_d}, {5'(r - 2), 5'(c - 2)});
        if (int'(wc_d) > maxcol) maxcol = int'(wc_d);
      end
      chk("big_done", done_d, (n == 783));
    end
    pv_d = 1'b0;
    @(posedge clk); #1;
    chk("big_strobes", strobes, 676);
    chk("big_maxcol", maxcol, 25);
    chk("big_idle", {busy_d, en_d, done_d}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
